// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encodings,
// PC step and default bubble word.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STALL = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] align_word(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction RAM bus between the fetch stage (master) and the RAM (slave).
// The RAM returns ram_data combinationally from ram_addr.
interface fetch_stage_if;

  logic        ram_en;
  logic [31:0] ram_addr;
  logic [31:0] ram_data;

  modport master (output ram_en, output ram_addr, input ram_data);
  modport slave  (input ram_en, input ram_addr, output ram_data);

endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Flush has priority over load; a flush inserts
// the bubble word, clears valid and keeps the previous pc4.
module if_id_reg #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc4_in,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        valid
);

  logic [31:0] instr_r;
  logic [31:0] pc4_r;
  logic        valid_r;

  // Pipeline register: flush inserts a bubble, load captures the fetched word.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_r <= NOP_WORD;
      pc4_r   <= 32'd0;
      valid_r <= 1'b0;
    end else if (flush) begin
      instr_r <= NOP_WORD;
      valid_r <= 1'b0;
    end else if (load) begin
      instr_r <= instr_in;
      pc4_r   <= pc4_in;
      valid_r <= 1'b1;
    end
  end

  assign instr = instr_r;
  assign pc4   = pc4_r;
  assign valid = valid_r;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction RAM and
// fills the IF/ID register. Handles hazard stalls and taken-branch flush.
// Optional feature macro FETCH_PERF_CNT_EN adds fetch/stall counters.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [31:0]        branch_target,
  fetch_stage_if.master      ram_bus,
  output logic [31:0]        if_id_instr,
  output logic [31:0]        if_id_pc4,
  output logic               if_id_valid,
  output logic [1:0]         fetch_state
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [31:0]        stall_count
`endif
);

  fetch_state_e state_r;
  fetch_state_e state_nxt_s;
  logic [31:0]  pc_r;
  logic [31:0]  pc_nxt_s;
  logic [31:0]  pc_plus_s;
  logic         ram_en_r;
  logic         load_s;
  logic         flush_s;

  assign pc_plus_s = pc_r + PC_STEP;

  // Next-state / next-PC decode; branch beats stall beats increment.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    load_s      = 1'b0;
    flush_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        state_nxt_s = ST_RUN;
      end
      ST_RUN, ST_STALL: begin
        if (branch_taken) begin
          pc_nxt_s    = align_word(branch_target);
          flush_s     = 1'b1;
          state_nxt_s = ST_RUN;
        end else if (stall) begin
          state_nxt_s = ST_STALL;
        end else begin
          pc_nxt_s    = pc_plus_s;
          load_s      = 1'b1;
          state_nxt_s = ST_RUN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, PC and RAM enable registers; enable follows the next state so
  // it is a plain flop output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r  <= ST_IDLE;
      pc_r     <= RESET_PC;
      ram_en_r <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      pc_r     <= pc_nxt_s;
      ram_en_r <= (state_nxt_s != ST_IDLE);
    end
  end

  assign ram_bus.ram_en   = ram_en_r;
  assign ram_bus.ram_addr = pc_r;
  assign fetch_state      = state_r;

  if_id_reg #(
    .NOP_WORD (NOP_WORD)
  ) u_if_id_reg (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load_s),
    .flush    (flush_s),
    .instr_in (ram_bus.ram_data),
    .pc4_in   (pc_plus_s),
    .instr    (if_id_instr),
    .pc4      (if_id_pc4),
    .valid    (if_id_valid)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_r;
  logic [31:0] stall_count_r;

  // Performance counters: valid loads and edges spent in STALL, wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_count_r <= 32'd0;
      stall_count_r <= 32'd0;
    end else begin
      if (load_s) begin
        fetch_count_r <= fetch_count_r + 32'd1;
      end
      if (state_r == ST_STALL) begin
        stall_count_r <= stall_count_r + 32'd1;
      end
    end
  end

  assign fetch_count = fetch_count_r;
  assign stall_count = stall_count_r;
`else
  // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the stimulus process pushes the
// hand-computed post-edge outputs, a monitor pops and compares each cycle.
module tb_fetch_stage;

  logic        clk;
  logic        reset_n;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic [1:0]  fetch_state;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
`endif

  fetch_stage_if ram_bus ();

  logic [31:0] mem [0:63];

  assign ram_bus.ram_data = mem[ram_bus.ram_addr[7:2]];

  fetch_stage dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .ram_bus       (ram_bus.master),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .fetch_state   (fetch_state)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count   (fetch_count),
    .stall_count   (stall_count)
`endif
  );

  typedef struct {
    logic [1:0]  st;
    logic        en;
    logic [31:0] addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic [31:0] fc;
    logic [31:0] sc;
  } exp_t;

  exp_t exp_q [$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   row_id   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s row %0d: got %h required %h", name, row_id, act, req);
  endtask

  // Monitor: compare the DUT against the oldest expectation on each falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check("fetch_state", {30'd0, fetch_state}, {30'd0, e.st});
      check("ram_en", {31'd0, ram_bus.ram_en}, {31'd0, e.en});
      check("ram_addr", ram_bus.ram_addr, e.addr);
      check("if_id_instr", if_id_instr, e.instr);
      check("if_id_pc4", if_id_pc4, e.pc4);
      check("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.valid});
`ifdef FETCH_PERF_CNT_EN
      check("fetch_count", fetch_count, e.fc);
      check("stall_count", stall_count, e.sc);
`endif
      row_id++;
    end
  end

  task automatic push_exp(input logic [1:0] st, input logic en, input logic [31:0] addr,
                          input logic [31:0] instr, input logic [31:0] pc4, input logic valid,
                          input logic [31:0] fc, input logic [31:0] sc);
    exp_t e;
    e.st = st; e.en = en; e.addr = addr; e.instr = instr;
    e.pc4 = pc4; e.valid = valid; e.fc = fc; e.sc = sc;
    exp_q.push_back(e);
  endtask

  // Drive inputs for the next rising edge and record what must follow it.
  task automatic step(input logic rst, input logic s, input logic b, input logic [31:0] t,
                      input logic [1:0] st, input logic en, input logic [31:0] addr,
                      input logic [31:0] instr, input logic [31:0] pc4, input logic valid,
                      input logic [31:0] fc, input logic [31:0] sc);
    @(negedge clk);
    #1;
    reset_n = rst; stall = s; branch_taken = b; branch_target = t;
    push_exp(st, en, addr, instr, pc4, valid, fc, sc);
  endtask

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'hC0DE_0000 + 32'(i * 4);
    reset_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'd0;

    //   rst  stl  br   target          st    en   addr           instr          pc4            v    fc  sc
    step(1'b0,1'b0,1'b0,32'h0000_0000,  2'd0, 1'b0,32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0,32'd0,32'd0);
    step(1'b1,1'b0,1'b0,32'h0000_0000,  2'd1, 1'b1,32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0,32'd0,32'd0);
    step(1'b1,1'b0,1'b0,32'h0000_0000,  2'd1, 1'b1,32'h0000_0004, 32'hC0DE_0000, 32'h0000_0004, 1'b1,32'd1,32'd0);
    step(1'b1,1'b0,1'b0,32'h0000_0000,  2'd1, 1'b1,32'h0000_0008, 32'hC0DE_0004, 32'h0000_0008, 1'b1,32'd2,32'd0);
    step(1'b1,1'b0,1'b0,32'h0000_0000,  2'd1, 1'b1,32'h0000_000C, 32'hC0DE_0008, 32'h0000_000C, 1'b1,32'd3,32'd0);
    step(1'b1,1'b0,1'b0,32'h0000_0000,  2'd1, 1'b1,32'h0000_0010, 32'hC0DE_000C, 32'h0000_0010, 1'b1,32'd4,32'd0);
    // three stalled edges, then release capture
    step(1'b1,1'b1,1'b0,32'h0000_0000,  2'd2, 1'b1,32'h0000_0010, 32'hC0DE_000C, 32'h0000_0010, 1'b1,32'd4,32'd0);
    step(1'b1,1'b1,1'b0,32'h0000_0000,  2'd2, 1'b1,32'h0000_0010, 32'hC0DE_000C, 32'h0000_0010, 1'b1,32'd4,32'd1);
    step(1'b1,1'b1,1'b0,32'h0000_0000,  2'd2, 1'b1,32'h0000_0010, 32'hC0DE_000C, 32'h0000_0010, 1'b1,32'd4,32'd2);
    step(1'b1,1'b0,1'b0,32'h0000_0000,  2'd1, 1'b1,32'h0000_0014, 32'hC0DE_0010, 32'h0000_0014, 1'b1,32'd5,32'd3);
    // taken branch to unaligned 0x13 -> 0x10, one bubble, then target word
    step(1'b1,1'b0,1'b1,32'h0000_0013,  2'd1, 1'b1,32'h0000_0010, 32'h0000_0000, 32'h0000_0014, 1'b0,32'd5,32'd3);
    step(1'b1,1'b0,1'b0,32'h0000_0000,  2'd1, 1'b1,32'h0000_0014, 32'hC0DE_0010, 32'h0000_0014, 1'b1,32'd6,32'd3);
    // branch while stalled with stall still high: branch wins, back to RUN
    step(1'b1,1'b1,1'b0,32'h0000_0000,  2'd2, 1'b1,32'h0000_0014, 32'hC0DE_0010, 32'h0000_0014, 1'b1,32'd6,32'd3);
    step(1'b1,1'b1,1'b1,32'h0000_0040,  2'd1, 1'b1,32'h0000_0040, 32'h0000_0000, 32'h0000_0014, 1'b0,32'd6,32'd4);
    step(1'b1,1'b0,1'b0,32'h0000_0000,  2'd1, 1'b1,32'h0000_0044, 32'hC0DE_0040, 32'h0000_0044, 1'b1,32'd7,32'd4);
    // wrap: branch to 0xFFFF_FFFF -> 0xFFFF_FFFC, then increment wraps to 0
    step(1'b1,1'b0,1'b1,32'hFFFF_FFFF,  2'd1, 1'b1,32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0044, 1'b0,32'd7,32'd4);
    step(1'b1,1'b0,1'b0,32'h0000_0000,  2'd1, 1'b1,32'h0000_0000, 32'hC0DE_00FC, 32'h0000_0000, 1'b1,32'd8,32'd4);
    step(1'b1,1'b0,1'b0,32'h0000_0000,  2'd1, 1'b1,32'h0000_0004, 32'hC0DE_0000, 32'h0000_0004, 1'b1,32'd9,32'd4);

    // async reset 2 ns after a rising edge; checked before the next edge
    @(negedge clk);
    #1;
    push_exp(2'd0, 1'b0, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0, 32'd0, 32'd0);
    @(posedge clk);
    #2;
    reset_n = 1'b0;

    // release with branch asserted in IDLE: ignored
    step(1'b1,1'b0,1'b1,32'h0000_0080,  2'd1, 1'b1,32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0,32'd0,32'd0);
    step(1'b1,1'b0,1'b0,32'h0000_0000,  2'd1, 1'b1,32'h0000_0004, 32'hC0DE_0000, 32'h0000_0004, 1'b1,32'd1,32'd0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #1;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
